capture_buf128: RTL and testbench
=================================

CAPTURE_BUF128 -- requirements
Module: capture_buf128

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of buffer depth in 128-bit beats.
REQ-002 SHALL have parameter ADR_BITS, default DEPTH_LOG2+3, Wishbone word-address width.
REQ-003 SHALL have port aclk  in  1  sole clock for stream, Wishbone and RAM.
REQ-004 SHALL have port aresetn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port capture_i  in  1  trigger, level-sampled on aclk.
REQ-006 SHALL have ports dat_tdata  in  128, dat_tvalid  in  1, dat_tready  out  1: AXI4-Stream target, 8 samples/beat.
REQ-007 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1; wb_adr_i  in  ADR_BITS; wb_dat_i  in  32; wb_sel_i  in  4: Wishbone target inputs.
REQ-008 SHALL have ports wb_ack_o, wb_err_o, wb_rty_o  out  1; wb_dat_o  out  32: Wishbone target outputs.
REQ-009 SHALL have port done_o  out  1  high while in DONE.

Function
REQ-010 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-011 SHALL assert dat_tready in every state once out of reset; beats not captured are discarded.
REQ-012 SHALL go ARMED from any state on a CTRL write with bit0=1, clearing write pointer and beat count.
REQ-013 SHALL go IDLE from any state on a CTRL write with bit1=1; bit1 SHALL win if bit0 and bit1 are both set.
REQ-014 SHALL, in ARMED, go CAPTURE on capture_i=1; if dat_tvalid is also high that cycle, the beat SHALL be written at address 0.
REQ-015 SHALL, in CAPTURE, write each beat with dat_tvalid&dat_tready at the pointer, then increment the pointer.
REQ-016 SHALL go DONE in the cycle the 2^DEPTH_LOG2-th beat is written; the pointer SHALL NOT wrap.
REQ-017 SHALL give a CTRL arm/abort write priority over capture_i and beat writes in the same cycle.
REQ-018 SHALL ignore capture_i in IDLE, CAPTURE and DONE.
REQ-019 SHALL decode wb_adr_i[ADR_BITS-1]=0 as memory: beat=adr[ADR_BITS-2:2], word k=adr[1:0] returns dat_tdata[32k+:32].
REQ-020 SHALL decode wb_adr_i[ADR_BITS-1]=1 as registers: offset 0 CTRL (W: bit0 arm, bit1 abort; reads 0); offset 1 STATUS (R: [1:0] state IDLE=0/ARMED=1/CAPTURE=2/DONE=3, [8] done, [26:16] beat count); other offsets read 0.
REQ-021 SHALL assert wb_ack_o for exactly one cycle, the cycle after cyc&stb is sampled, for reads and writes alike; wb_ack_o SHALL stay low the cycle after an ack.
REQ-022 SHALL ignore memory-space writes but still ack them; wb_sel_i SHALL be ignored.
REQ-023 SHALL hold wb_err_o and wb_rty_o at 0.
REQ-024 SHALL allow memory reads in any state; reads during CAPTURE return current RAM contents without interlock.

Reset
REQ-025 SHALL on aresetn=0 force state IDLE, pointer 0, count 0, wb_ack_o 0, wb_dat_o 0, done_o 0, dat_tready 0.
REQ-026 SHALL drive dat_tready 1 starting the first aclk edge after aresetn deasserts.
REQ-027 SHALL leave RAM contents undefined after reset and not clear them.

Structure
REQ-028 SHALL put the state enum, register offsets and STATUS bit positions in package capture_buf_pkg.
REQ-029 SHALL instantiate one sub-module, capture_buf_ram: simple dual-port, 128-bit write, 128-bit registered read, 1-cycle latency; the 32-bit word mux follows the RAM.

Verification
REQ-030 SHALL check: reset, then arm, capture_i=1 for one cycle, 1024 beats of incrementing pattern -> done_o=1 after beat 1024; STATUS=0x0400_0103.
REQ-031 SHALL check: after capture, read adr 0x0005 -> tdata[63:32] of beat 1; read adr 0x0FFF -> tdata[127:96] of beat 1023; each ack is one cycle, one cycle after stb.
REQ-032 SHALL check: arm with tvalid gapped 50% -> exactly 1024 valid beats stored in order; gap beats not stored.
REQ-033 SHALL check: CTRL write 0x1 in the same cycle as capture_i=1 -> state ARMED, count 0, no beat written.
REQ-034 SHALL check: abort (0x2) at beat 300 -> STATUS state=0, count=300; then capture_i pulse -> state stays IDLE.
REQ-035 SHALL check: aresetn low mid-CAPTURE -> dat_tready=0 and done_o=0 immediately; then STATUS reads 0 after release.

Source files
------------

// File: rtl/capture_buf_pkg.sv
// Shared constants for the 128-bit capture buffer: FSM encoding, register map
// and STATUS field layout, plus a helper that packs the STATUS word.
package capture_buf_pkg;

  // FSM state encoding (also the STATUS[1:0] read value)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Register-space word offsets
  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;

  // CTRL write bits
  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // STATUS field positions
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_DONE_BIT  = 8;
  localparam int STATUS_COUNT_LSB = 16;
  localparam int STATUS_COUNT_W   = 11;

  function automatic logic [31:0] pack_status(input logic [1:0] state,
                                              input logic [STATUS_COUNT_W-1:0] count);
    logic [31:0] s;
    s = '0;
    s[STATUS_STATE_LSB +: 2] = state;
    s[STATUS_DONE_BIT] = (state == ST_DONE);
    s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/capture_buf_ram.sv
// Simple dual-port beat store: one 128-bit write port, one 128-bit read port
// with a registered output (one cycle latency). Contents are never reset.
module capture_buf_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_reg;

  // Write port: store one beat when enabled
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output so the array maps onto block RAM
  always_ff @(posedge aclk) begin
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/capture_buf128.sv
// One-shot capture of a 128-bit AXI4-Stream into on-chip RAM, armed and
// inspected over a Wishbone target. The stream is always accepted; beats are
// only stored between a capture trigger and the buffer filling up.
module capture_buf128
  import capture_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADR_BITS   = DEPTH_LOG2 + 3
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                capture_i,
  input  logic [127:0]        dat_tdata,
  input  logic                dat_tvalid,
  output logic                dat_tready,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADR_BITS-1:0] wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         wb_dat_o,
  output logic                done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int OFF_W = ADR_BITS - 1;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             tready_reg;
  logic             ack_reg;
  logic             mem_sel_reg;
  logic [1:0]       word_sel_reg;
  logic [31:0]      reg_rdata_reg;

  logic             wb_req, reg_space, ctrl_wr, arm, abort;
  logic             beat, capturing, ram_we;
  logic [OFF_W-1:0] reg_off;
  logic [127:0]     ram_rdata;
  logic [31:0]      ram_words [4];
  logic             unused_inputs;

  // A request is taken only when no ack is pending, so acks never run back to back
  assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign reg_space = wb_adr_i[ADR_BITS-1];
  assign reg_off   = wb_adr_i[OFF_W-1:0];
  assign ctrl_wr   = wb_req & wb_we_i & reg_space & (reg_off == OFF_W'(REG_CTRL));
  assign abort     = ctrl_wr & wb_dat_i[CTRL_ABORT_BIT];
  assign arm       = ctrl_wr & wb_dat_i[CTRL_ARM_BIT] & ~wb_dat_i[CTRL_ABORT_BIT];

  // The trigger cycle itself stores a beat, so ARMED+capture counts as capturing
  assign beat      = dat_tvalid & tready_reg;
  assign capturing = (state_reg == ST_CAPTURE) | ((state_reg == ST_ARMED) & capture_i);
  assign ram_we    = beat & capturing & ~abort & ~arm;

  // Next-state logic: control writes beat the trigger and stream writes
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (arm) begin
      state_next = ST_ARMED;
      count_next = '0;
    end else if (ram_we) begin
      count_next = count_reg + CNT_W'(1);
      state_next = (count_reg == CNT_W'(DEPTH - 1)) ? ST_DONE : ST_CAPTURE;
    end else if (capturing) begin
      state_next = ST_CAPTURE;
    end
  end

  // FSM, beat counter and stream-ready registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      tready_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      tready_reg <= 1'b1;
    end
  end

  // Wishbone response: ack one cycle after the request, latch read selection
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack_reg       <= 1'b0;
      mem_sel_reg   <= 1'b0;
      word_sel_reg  <= 2'd0;
      reg_rdata_reg <= 32'd0;
    end else begin
      ack_reg <= wb_req;
      if (wb_req) begin
        mem_sel_reg  <= ~reg_space;
        word_sel_reg <= wb_adr_i[1:0];
        if (reg_space && !wb_we_i && reg_off == OFF_W'(REG_STATUS))
          reg_rdata_reg <= pack_status(state_reg, STATUS_COUNT_W'(count_reg));
        else
          reg_rdata_reg <= 32'd0;
      end
    end
  end

  // The count is the write pointer; it stops at DEPTH because DONE stops writes
  capture_buf_ram #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(128)
  ) u_ram (
    .aclk  (aclk),
    .we    (ram_we),
    .waddr (count_reg[DEPTH_LOG2-1:0]),
    .wdata (dat_tdata),
    .raddr (wb_adr_i[2 +: DEPTH_LOG2]),
    .rdata (ram_rdata)
  );

  // Split the RAM output into its four 32-bit words
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign ram_words[gi] = ram_rdata[32*gi +: 32];
  end

  // Read data is only driven in the ack cycle; zero otherwise and in reset
  always_comb begin
    wb_dat_o = 32'd0;
    if (ack_reg) wb_dat_o = mem_sel_reg ? ram_words[word_sel_reg] : reg_rdata_reg;
  end

  assign wb_ack_o   = ack_reg;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign dat_tready = tready_reg;
  assign done_o     = (state_reg == ST_DONE);

  // Byte selects and upper CTRL bits have no function here
  assign unused_inputs = ^{wb_sel_i, wb_dat_i[31:2]};

endmodule

// File: tb/tb_capture_buf128.sv
// Randomized bench for capture_buf128 with a behavioural model of the buffer
// (expected state, beat count and stored beats kept as plain variables).
module tb_capture_buf128;

  localparam int ADR_BITS = 13;
  localparam int DEPTH    = 1024;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;
  localparam logic [12:0] A_CTRL   = 13'h1000;
  localparam logic [12:0] A_STATUS = 13'h1001;

  logic          aclk;
  logic          aresetn;
  logic          capture_i;
  logic [127:0]  dat_tdata;
  logic          dat_tvalid;
  logic          dat_tready;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [12:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0]   wb_dat_o;
  logic          done_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int           m_state;
  int           m_count;
  bit           m_ready;
  logic [127:0] m_mem [DEPTH];

  capture_buf128 dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .capture_i (capture_i),
    .dat_tdata (dat_tdata),
    .dat_tvalid(dat_tvalid),
    .dat_tready(dat_tready),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .wb_dat_o  (wb_dat_o),
    .done_o    (done_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [127:0] d;
    for (int s = 0; s < 8; s++) d[16*s +: 16] = 16'(8*n + s);
    return d;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] exp_status();
    return (32'(m_count) << 16) | ((m_state == S_DONE) ? 32'h100 : 32'h0) | 32'(m_state);
  endfunction

  function automatic logic [31:0] exp_read(input logic [12:0] adr);
    logic [127:0] b;
    if (adr[12]) return (adr[11:0] == 12'd1) ? exp_status() : 32'h0;
    b = m_mem[adr[11:2]];
    return b[32*adr[1:0] +: 32];
  endfunction

  // Behaviour at one clock edge, from the buffer's rules
  task automatic model_edge();
    bit ctrl, do_abort, do_arm, take;
    if (!aresetn) begin
      m_state = S_IDLE; m_count = 0; m_ready = 0;
      return;
    end
    ctrl     = wb_cyc_i && wb_stb_i && wb_we_i && wb_adr_i[12] && (wb_adr_i[11:0] == 12'd0);
    do_abort = ctrl && wb_dat_i[1];
    do_arm   = ctrl && wb_dat_i[0] && !do_abort;
    take     = dat_tvalid && m_ready &&
               (m_state == S_CAPTURE || (m_state == S_ARMED && capture_i));
    if (do_abort) m_state = S_IDLE;
    else if (do_arm) begin
      m_state = S_ARMED; m_count = 0;
    end else if (take) begin
      m_mem[m_count] = dat_tdata;
      m_count++;
      m_state = (m_count == DEPTH) ? S_DONE : S_CAPTURE;
    end else if (m_state == S_ARMED && capture_i) m_state = S_CAPTURE;
    m_ready = 1;
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  // Bus transactions quiet the stream after the request cycle
  task automatic wb_write(input logic [12:0] adr, input logic [31:0] dat, input string tag);
    check({tag, "_ack_idle"}, 32'(wb_ack_o), 32'h0);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 4'hf;
    step();
    capture_i = 0; dat_tvalid = 0;
    check({tag, "_ack"}, 32'(wb_ack_o), 32'h1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    step();
    check({tag, "_ack_drop"}, 32'(wb_ack_o), 32'h0);
    $display("wb wr adr=%h dat=%h %s", adr, dat, tag);
  endtask

  task automatic wb_read(input logic [12:0] adr, input string tag, output logic [31:0] rd);
    logic [31:0] exp;
    exp = exp_read(adr);
    check({tag, "_ack_idle"}, 32'(wb_ack_o), 32'h0);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr; wb_sel_i = 4'hf;
    step();
    capture_i = 0; dat_tvalid = 0;
    check({tag, "_ack"}, 32'(wb_ack_o), 32'h1);
    check({tag, "_data"}, wb_dat_o, exp);
    rd = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0;
    step();
    check({tag, "_ack_drop"}, 32'(wb_ack_o), 32'h0);
    $display("wb rd adr=%h dat=%h exp=%h %s", adr, rd, exp, tag);
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    aresetn = 0; capture_i = 0; dat_tdata = '0; dat_tvalid = 0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    m_state = S_IDLE; m_count = 0; m_ready = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", 32'(dat_tready), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_ack", 32'(wb_ack_o), 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    aresetn = 1;
    #1;
    check("rel_tready_low", 32'(dat_tready), 32'h0);
    step();
    check("rel_tready_high", 32'(dat_tready), 32'h1);
    check("err_zero", 32'(wb_err_o), 32'h0);
    check("rty_zero", 32'(wb_rty_o), 32'h0);
    wb_read(A_STATUS, "status_rst", rd);
    check("status_rst_const", rd, 32'h0);

    // full capture of incrementing pattern
    wb_write(A_CTRL, 32'h1, "arm_a");
    for (int n = 0; n < DEPTH; n++) begin
      capture_i = (n == 0); dat_tvalid = 1; dat_tdata = pat(n);
      step();
      if (n == DEPTH - 2) check("done_early", 32'(done_o), 32'h0);
    end
    check("done_full", 32'(done_o), 32'h1);
    for (int n = 0; n < 4; n++) begin
      capture_i = 0; dat_tvalid = 1; dat_tdata = pat(5000 + n);
      step();
    end
    dat_tvalid = 0;
    wb_read(A_STATUS, "status_full", rd);
    check("status_full_const", rd, 32'h0400_0103);
    wb_read(13'h0005, "beat1_w1", rd);
    check("beat1_w1_const", rd, 32'h000B_000A);
    wb_read(13'h0FFF, "beat1023_w3", rd);
    check("beat1023_w3_const", rd, 32'h1FFF_1FFE);
    wb_read(13'h0000, "beat0_nowrap", rd);
    check("beat0_nowrap_const", rd, 32'h0001_0000);
    wb_read(13'h1002, "reg_other", rd);
    wb_write(13'h0004, 32'hDEAD_BEEF, "memwr_ignored");
    wb_read(13'h0004, "memwr_ignored_rd", rd);
    for (int i = 0; i < 8; i++)
      wb_read({1'b0, 12'($urandom_range(0, 4095))}, "rand_rd", rd);

    // held strobe: ack, gap, ack
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = A_STATUS;
    step(); check("hold_ack1", 32'(wb_ack_o), 32'h1);
    check("hold_dat1", wb_dat_o, exp_status());
    step(); check("hold_gap", 32'(wb_ack_o), 32'h0);
    step(); check("hold_ack2", 32'(wb_ack_o), 32'h1);
    wb_cyc_i = 0; wb_stb_i = 0;
    step(); check("hold_drop", 32'(wb_ack_o), 32'h0);

    // 50% gapped stream with random data
    wb_write(A_CTRL, 32'h1, "arm_b");
    capture_i = 1; dat_tvalid = 1'($urandom_range(0, 1)); dat_tdata = rand128();
    step();
    capture_i = 0;
    cyc = 0;
    while (m_state != S_DONE && cyc < 6000) begin
      dat_tvalid = 1'($urandom_range(0, 1)); dat_tdata = rand128();
      step();
      cyc++;
    end
    dat_tvalid = 0;
    if (cyc >= 6000) check("gap_bound", 32'(cyc), 32'h0);
    check("gap_done", 32'(done_o), 32'h1);
    wb_read(A_STATUS, "gap_status", rd);
    for (int b = 0; b < DEPTH; b++)
      wb_read({1'b0, 10'(b), 2'($urandom_range(0, 3))}, "gap_beat", rd);

    // arm in the same cycle as the trigger and a valid beat
    wb_write(A_CTRL, 32'h1, "arm_c");
    capture_i = 1; dat_tvalid = 1; dat_tdata = rand128();
    wb_write(A_CTRL, 32'h1, "arm_vs_cap");
    wb_read(A_STATUS, "arm_vs_cap_status", rd);
    check("arm_vs_cap_const", rd, 32'h0000_0001);
    wb_read(13'h0000, "arm_vs_cap_beat0", rd);

    // abort at beat 300, abort beating a beat write, then trigger ignored
    for (int n = 0; n < 300; n++) begin
      capture_i = (n == 0); dat_tvalid = 1; dat_tdata = rand128();
      step();
    end
    capture_i = 0; dat_tvalid = 1; dat_tdata = rand128();
    wb_write(A_CTRL, 32'h2, "abort");
    wb_read(A_STATUS, "abort_status", rd);
    check("abort_const", rd, 32'h012C_0000);
    capture_i = 1; dat_tvalid = 1; dat_tdata = rand128();
    step();
    capture_i = 0; dat_tvalid = 0;
    wb_read(A_STATUS, "idle_cap_status", rd);
    check("idle_cap_const", rd, 32'h012C_0000);
    wb_write(A_CTRL, 32'h1, "arm_d");
    wb_write(A_CTRL, 32'h3, "both_bits");
    wb_read(A_STATUS, "both_bits_status", rd);
    check("both_bits_const", rd, 32'h0000_0000);

    // reset mid-capture
    wb_write(A_CTRL, 32'h1, "arm_e");
    for (int n = 0; n < 100; n++) begin
      capture_i = (n == 0); dat_tvalid = 1; dat_tdata = rand128();
      step();
    end
    capture_i = 0;
    aresetn = 0;
    #1;
    check("midrst_tready", 32'(dat_tready), 32'h0);
    check("midrst_done", 32'(done_o), 32'h0);
    m_state = S_IDLE; m_count = 0; m_ready = 0;
    dat_tvalid = 0;
    step();
    aresetn = 1;
    step();
    check("midrst_tready_back", 32'(dat_tready), 32'h1);
    wb_read(A_STATUS, "midrst_status", rd);
    check("midrst_status_const", rd, 32'h0);

    // reset while DONE drops done_o at once
    wb_write(A_CTRL, 32'h1, "arm_f");
    for (int n = 0; n < DEPTH; n++) begin
      capture_i = (n == 0); dat_tvalid = 1; dat_tdata = rand128();
      step();
    end
    capture_i = 0; dat_tvalid = 0;
    check("done_before_rst", 32'(done_o), 32'h1);
    aresetn = 0;
    #1;
    check("donerst_done", 32'(done_o), 32'h0);
    check("donerst_tready", 32'(dat_tready), 32'h0);
    m_state = S_IDLE; m_count = 0; m_ready = 0;
    step();
    aresetn = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
